// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage: register file, control decode, load-use hazard stall
package decode_stage_pkg;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;
endpackage

module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] instr,
    input  logic [31:0] npc_in,
    input  logic        ifid_valid,
    input  logic        ex_DRen,
    input  logic [4:0]  ex_Rt,
    input  logic        flush,
    input  logic        wb_WEN,
    input  logic [4:0]  wb_wsel,
    input  logic [31:0] wb_wdat,
    output logic [31:0] rdat1,
    output logic [31:0] rdat2,
    output logic [31:0] extout,
    output logic [31:0] Jaddr,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [31:0] npc_out,
    output aluop_t      ALUop,
    output logic [1:0]  RegDest,
    output logic [1:0]  Mem,
    output logic        RegW,
    output logic        Branch,
    output logic        BNE,
    output logic        jump,
    output logic        jr,
    output logic        lui,
    output logic        DWen,
    output logic        DRen,
    output logic        ALUsource,
    output logic        halt,
    output logic        stall,
    output logic        halted,
    output logic [31:0] stall_count
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [31:0][31:0] regs_q, regs_d;
    logic              halted_q, halted_d;
    logic [31:0]       stall_count_q, stall_count_d;

    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    aluop_t      dec_alu;
    logic [1:0]  dec_reg_dest, dec_mem;
    logic        dec_reg_w, dec_branch, dec_bne, dec_jump, dec_jr, dec_lui;
    logic        dec_dwen, dec_dren, dec_alusrc, dec_halt, dec_zext, reads_rt;
    logic        hazard, squash;

    assign opcode  = instr[31:26];
    assign funct   = instr[5:0];
    assign imm     = instr[15:0];
    assign Rs      = instr[25:21];
    assign Rt      = instr[20:16];
    assign Rd      = instr[15:11];
    assign npc_out = npc_in;
    assign Jaddr   = {npc_in[31:28], instr[25:0], 2'b00};

    // Register reads see a same-cycle writeback so WB needs no extra forwarding path.
    always_comb begin
        rdat1 = regs_q[Rs];
        rdat2 = regs_q[Rt];
        if (wb_WEN && (wb_wsel == Rs)) rdat1 = wb_wdat;
        if (wb_WEN && (wb_wsel == Rt)) rdat2 = wb_wdat;
        if (Rs == 5'd0) rdat1 = 32'd0;
        if (Rt == 5'd0) rdat2 = 32'd0;
    end

    always_comb begin
        dec_alu      = ALU_SLL;
        dec_reg_dest = 2'b00;
        dec_mem      = 2'b00;
        dec_reg_w    = 1'b0;
        dec_branch   = 1'b0;
        dec_bne      = 1'b0;
        dec_jump     = 1'b0;
        dec_jr       = 1'b0;
        dec_lui      = 1'b0;
        dec_dwen     = 1'b0;
        dec_dren     = 1'b0;
        dec_alusrc   = 1'b0;
        dec_halt     = 1'b0;
        dec_zext     = 1'b0;
        reads_rt     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_dest = 2'b01;
                dec_reg_w    = 1'b1;
                reads_rt     = 1'b1;
                case (funct)
                    FN_SLL:          dec_alu = ALU_SLL;
                    FN_SRL:          dec_alu = ALU_SRL;
                    FN_JR: begin
                        dec_jr    = 1'b1;
                        dec_reg_w = 1'b0;
                    end
                    FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_alu = ALU_SUB;
                    FN_AND:          dec_alu = ALU_AND;
                    FN_OR:           dec_alu = ALU_OR;
                    FN_XOR:          dec_alu = ALU_XOR;
                    FN_NOR:          dec_alu = ALU_NOR;
                    FN_SLT:          dec_alu = ALU_SLT;
                    FN_SLTU:         dec_alu = ALU_SLTU;
                    default:         dec_alu = ALU_SLL;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_alusrc = 1'b1;
                dec_reg_w  = 1'b1;
                case (opcode)
                    OP_SLTI:  dec_alu = ALU_SLT;
                    OP_SLTIU: dec_alu = ALU_SLTU;
                    OP_ANDI:  dec_alu = ALU_AND;
                    OP_ORI:   dec_alu = ALU_OR;
                    OP_XORI:  dec_alu = ALU_XOR;
                    default:  dec_alu = ALU_ADD;
                endcase
                dec_lui  = (opcode == OP_LUI);
                dec_zext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
            end
            OP_LW: begin
                dec_dren   = 1'b1;
                dec_mem    = 2'b01;
                dec_reg_w  = 1'b1;
                dec_alusrc = 1'b1;
                dec_alu    = ALU_ADD;
            end
            OP_SW: begin
                dec_dwen   = 1'b1;
                dec_alusrc = 1'b1;
                dec_alu    = ALU_ADD;
                reads_rt   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_branch = 1'b1;
                dec_bne    = (opcode == OP_BNE);
                dec_alu    = ALU_SUB;
                reads_rt   = 1'b1;
            end
            OP_J:   dec_jump = 1'b1;
            OP_JAL: begin
                dec_jump     = 1'b1;
                dec_reg_w    = 1'b1;
                dec_reg_dest = 2'b10;
                dec_mem      = 2'b10;
            end
            OP_HALT: dec_halt = 1'b1;
            default: dec_halt = 1'b0;
        endcase
    end

    assign extout = dec_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

    // Flush, halt and reset all win over a load-use stall.
    assign hazard = ex_DRen && (ex_Rt != 5'd0) && ifid_valid &&
                    ((ex_Rt == Rs) || (reads_rt && (ex_Rt == Rt)));
    assign stall  = hazard && !flush && !halted_q && !RST;
    assign squash = stall || flush || !ifid_valid || halted_q || RST;

    assign ALUop     = dec_alu;
    assign RegDest   = dec_reg_dest;
    assign Mem       = dec_mem;
    assign BNE       = dec_bne;
    assign lui       = dec_lui;
    assign ALUsource = dec_alusrc;
    assign RegW      = dec_reg_w  && !squash;
    assign Branch    = dec_branch && !squash;
    assign jump      = dec_jump   && !squash;
    assign jr        = dec_jr     && !squash;
    assign DWen      = dec_dwen   && !squash;
    assign DRen      = dec_dren   && !squash;
    assign halt      = dec_halt   && !squash;

    assign halted      = halted_q;
    assign stall_count = stall_count_q;

    always_comb begin
        regs_d = regs_q;
        if (wb_WEN && (wb_wsel != 5'd0)) regs_d[wb_wsel] = wb_wdat;
        halted_d      = halted_q || halt;
        stall_count_d = stall_count_q + {31'd0, stall};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs_q        <= '0;
            halted_q      <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            regs_q        <= regs_d;
            halted_q      <= halted_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        CLK, RST;
    logic [31:0] instr, npc_in;
    logic        ifid_valid, ex_DRen, flush, wb_WEN;
    logic [4:0]  ex_Rt, wb_wsel;
    logic [31:0] wb_wdat;
    logic [31:0] rdat1, rdat2, extout, Jaddr, npc_out, stall_count;
    logic [4:0]  Rs, Rt, Rd;
    aluop_t      ALUop;
    logic [1:0]  RegDest, Mem;
    logic        RegW, Branch, BNE, jump, jr, lui, DWen, DRen, ALUsource, halt, stall, halted;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .CLK(CLK), .RST(RST), .instr(instr), .npc_in(npc_in), .ifid_valid(ifid_valid),
        .ex_DRen(ex_DRen), .ex_Rt(ex_Rt), .flush(flush), .wb_WEN(wb_WEN),
        .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .rdat1(rdat1), .rdat2(rdat2),
        .extout(extout), .Jaddr(Jaddr), .Rs(Rs), .Rt(Rt), .Rd(Rd), .npc_out(npc_out),
        .ALUop(ALUop), .RegDest(RegDest), .Mem(Mem), .RegW(RegW), .Branch(Branch),
        .BNE(BNE), .jump(jump), .jr(jr), .lui(lui), .DWen(DWen), .DRen(DRen),
        .ALUsource(ALUsource), .halt(halt), .stall(stall), .halted(halted),
        .stall_count(stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    initial begin
        RST = 1'b1; instr = itype(6'h23, 5'd1, 5'd2, 16'h0004); npc_in = 32'h0000_0004;
        ifid_valid = 1'b1; ex_DRen = 1'b0; ex_Rt = 5'd0; flush = 1'b0;
        wb_WEN = 1'b0; wb_wsel = 5'd0; wb_wdat = 32'd0;
        #1;
        chk("rst_dren", {31'd0, DRen}, 32'd0);
        chk("rst_regw", {31'd0, RegW}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        tick(); tick();
        RST = 1'b0;

        // r5 = 0x1234, then ADDU r3,r5,r0
        ifid_valid = 1'b0; wb_WEN = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'h1234;
        tick();
        wb_WEN = 1'b0; ifid_valid = 1'b1; instr = rtype(5'd5, 5'd0, 5'd3, 6'h21);
        #1;
        chk("addu_rdat1", rdat1, 32'h0000_1234);
        chk("addu_rdat2", rdat2, 32'd0);
        chk("addu_regw", {31'd0, RegW}, 32'd1);
        chk("addu_regdest", {30'd0, RegDest}, 32'd1);
        chk("addu_rd", {27'd0, Rd}, 32'd3);
        chk("addu_aluop", {28'd0, ALUop}, {28'd0, ALU_ADD});

        // same-cycle bypass: ORI r9,r7,0xFFFF while writing r7
        wb_WEN = 1'b1; wb_wsel = 5'd7; wb_wdat = 32'hAA; instr = itype(6'h0D, 5'd7, 5'd9, 16'hFFFF);
        #1;
        chk("ori_bypass", rdat1, 32'h0000_00AA);
        chk("ori_extout", extout, 32'h0000_FFFF);
        chk("ori_alusrc", {31'd0, ALUsource}, 32'd1);
        chk("ori_regdest", {30'd0, RegDest}, 32'd0);
        tick();
        wb_WEN = 1'b0;
        #1;
        chk("r7_stored", rdat1, 32'h0000_00AA);
        wb_WEN = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'hDEAD; instr = rtype(5'd0, 5'd0, 5'd1, 6'h21);
        #1;
        chk("r0_bypass", rdat1, 32'd0);
        tick();
        wb_WEN = 1'b0;
        #1;
        chk("r0_stored", rdat2, 32'd0);

        // immediate / jump decodes
        instr = itype(6'h09, 5'd0, 5'd4, 16'hFFFF);
        #1;
        chk("addiu_extout", extout, 32'hFFFF_FFFF);
        instr = itype(6'h0F, 5'd0, 5'd4, 16'h1234);
        #1;
        chk("lui_flag", {31'd0, lui}, 32'd1);
        chk("lui_regw", {31'd0, RegW}, 32'd1);
        instr = {6'h02, 26'h000_0010}; npc_in = 32'h4000_0004;
        #1;
        chk("j_jaddr", Jaddr, 32'h4000_0040);
        chk("j_jump", {31'd0, jump}, 32'd1);
        chk("j_regw", {31'd0, RegW}, 32'd0);
        chk("npc_pass", npc_out, 32'h4000_0004);
        instr = {6'h03, 26'h000_0100};
        #1;
        chk("jal_regdest", {30'd0, RegDest}, 32'd2);
        chk("jal_mem", {30'd0, Mem}, 32'd2);
        chk("jal_regw", {31'd0, RegW}, 32'd1);
        instr = itype(6'h23, 5'd2, 5'd6, 16'h0008);
        #1;
        chk("lw_dren", {31'd0, DRen}, 32'd1);
        chk("lw_mem", {30'd0, Mem}, 32'd1);
        instr = itype(6'h2B, 5'd2, 5'd6, 16'h0008);
        #1;
        chk("sw_dwen", {31'd0, DWen}, 32'd1);
        chk("sw_regw", {31'd0, RegW}, 32'd0);
        instr = itype(6'h05, 5'd1, 5'd2, 16'hFFFE);
        #1;
        chk("bne_branch", {31'd0, Branch}, 32'd1);
        chk("bne_bne", {31'd0, BNE}, 32'd1);
        chk("bne_extout", extout, 32'hFFFF_FFFE);
        instr = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        #1;
        chk("jr_jr", {31'd0, jr}, 32'd1);
        chk("jr_regw", {31'd0, RegW}, 32'd0);
        instr = itype(6'h3E, 5'd1, 5'd2, 16'h0001);
        #1;
        chk("unk_regw", {31'd0, RegW}, 32'd0);
        chk("unk_alusrc", {31'd0, ALUsource}, 32'd0);

        // load-use hazard on Rs
        ex_DRen = 1'b1; ex_Rt = 5'd8; instr = rtype(5'd8, 5'd2, 5'd1, 6'h21);
        #1;
        chk("haz_stall", {31'd0, stall}, 32'd1);
        chk("haz_regw", {31'd0, RegW}, 32'd0);
        chk("haz_count_pre", stall_count, 32'd0);
        tick();
        chk("haz_count_post", stall_count, 32'd1);
        ex_Rt = 5'd0;
        #1;
        chk("rt0_stall", {31'd0, stall}, 32'd0);
        chk("rt0_regw", {31'd0, RegW}, 32'd1);
        tick();
        chk("rt0_count", stall_count, 32'd1);
        ex_Rt = 5'd8; instr = itype(6'h09, 5'd2, 5'd8, 16'h0001);
        #1;
        chk("addiu_rt_nostall", {31'd0, stall}, 32'd0);
        instr = itype(6'h2B, 5'd2, 5'd8, 16'h0000);
        #1;
        chk("sw_rt_stall", {31'd0, stall}, 32'd1);

        // flush beats stall
        flush = 1'b1; instr = rtype(5'd8, 5'd2, 5'd1, 6'h21);
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_regw", {31'd0, RegW}, 32'd0);
        tick();
        chk("flush_count", stall_count, 32'd1);
        flush = 1'b0; ex_DRen = 1'b0;

        // halt becomes sticky and bubbles everything after it
        instr = {6'h3F, 26'd0};
        #1;
        chk("halt_out", {31'd0, halt}, 32'd1);
        chk("halted_pre", {31'd0, halted}, 32'd0);
        tick();
        chk("halted_post", {31'd0, halted}, 32'd1);
        ex_DRen = 1'b1; ex_Rt = 5'd8; instr = rtype(5'd8, 5'd2, 5'd1, 6'h21);
        #1;
        chk("halted_stall", {31'd0, stall}, 32'd0);
        chk("halted_regw", {31'd0, RegW}, 32'd0);
        ex_DRen = 1'b0; instr = {6'h02, 26'h000_0010};
        #1;
        chk("halted_jump", {31'd0, jump}, 32'd0);
        wb_WEN = 1'b1; wb_wsel = 5'd10; wb_wdat = 32'h55;
        tick();
        wb_WEN = 1'b0; instr = rtype(5'd10, 5'd0, 5'd0, 6'h21);
        #1;
        chk("halted_write", rdat1, 32'h0000_0055);
        chk("halted_count", stall_count, 32'd1);

        // reset mid-run, with a write coinciding with the reset edge
        RST = 1'b1; wb_WEN = 1'b1; wb_wsel = 5'd12; wb_wdat = 32'h77;
        #1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_r10", rdat1, 32'd0);
        chk("rst2_count", stall_count, 32'd0);
        tick();
        RST = 1'b0; wb_WEN = 1'b0; instr = rtype(5'd12, 5'd0, 5'd0, 6'h21);
        #1;
        chk("rst2_r12", rdat1, 32'd0);

        // reset in the middle of a stall
        ex_DRen = 1'b1; ex_Rt = 5'd4; instr = rtype(5'd4, 5'd1, 5'd1, 6'h21);
        #1;
        chk("rst3_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("rst3_count1", stall_count, 32'd1);
        RST = 1'b1;
        #1;
        chk("rst3_stall_rst", {31'd0, stall}, 32'd0);
        chk("rst3_count_rst", stall_count, 32'd0);
        tick();
        RST = 1'b0; ex_DRen = 1'b0;
        tick();
        chk("rst3_count_after", stall_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
